// File: rtl/shift_unit_seq.sv
// Multicycle 32-bit shifter: one 1-bit SLL or SRA step per clock, with a one-cycle ready pulse.
// Operands are captured on an accepted start, so later input changes cannot disturb the operation.
module shift_unit_seq (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic        op,
   input  logic [31:0] operand,
   input  logic [4:0]  shamt,
   output logic        busy,
   output logic        ready,
   output logic [31:0] result
);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StShift = 2'd1;
   localparam logic [1:0] StDone  = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [31:0] work_q, work_d;
   logic        op_q, op_d;
   logic [4:0]  cnt_q, cnt_d;

   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               work_d  = operand;
               op_d    = op;
               cnt_d   = shamt;
               state_d = (shamt == 5'd0) ? StDone : StShift;
            end
         end
         StShift: begin
            work_d = op_q ? {work_q[31], work_q[31:1]} : {work_q[30:0], 1'b0};
            // Guard keeps the counter from wrapping even if entered with zero.
            if (cnt_q != 5'd0) begin
               cnt_d = cnt_q - 5'd1;
            end
            if (cnt_q <= 5'd1) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         work_q  <= 32'h0;
         op_q    <= 1'b0;
         cnt_q   <= 5'd0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy   = (state_q == StShift);
   assign ready  = (state_q == StDone);
   assign result = work_q;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Directed self-checking bench for shift_unit_seq with hand-computed expected values.
module tb_shift_unit_seq;

   logic        clock;
   logic        reset;
   logic        start;
   logic        op;
   logic [31:0] operand;
   logic [4:0]  shamt;
   logic        busy;
   logic        ready;
   logic [31:0] result;

   int passed = 0;
   int total  = 0;

   shift_unit_seq dut (
      .clock   (clock),
      .reset   (reset),
      .start   (start),
      .op      (op),
      .operand (operand),
      .shamt   (shamt),
      .busy    (busy),
      .ready   (ready),
      .result  (result)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Accept on edge 0, then count busy cycles until ready, checking exclusivity on the way.
   task automatic run_op(input string tag, input logic o, input logic [31:0] a,
                         input logic [4:0] n, input logic [31:0] exp);
      int nbusy;
      int overlap;
      op = o; operand = a; shamt = n; start = 1'b1;
      tick();
      start = 1'b0;
      operand = ~a;
      shamt = 5'd7;
      op = ~o;
      nbusy = 0;
      overlap = 0;
      while (busy && nbusy < 40) begin
         if (ready) overlap++;
         nbusy++;
         tick();
      end
      check({tag, " busy cycles"}, nbusy, n);
      check({tag, " overlap"}, overlap, 0);
      check({tag, " ready"}, ready, 1'b1);
      check({tag, " result"}, result, exp);
      tick();
      check({tag, " ready drop"}, ready, 1'b0);
      check({tag, " result hold"}, result, exp);
   endtask

   initial begin
      int nbusy;
      int nready;
      reset = 1'b1; start = 1'b0; op = 1'b0; operand = 32'h0; shamt = 5'd0;
      #3;
      check("reset busy", busy, 1'b0);
      check("reset ready", ready, 1'b0);
      check("reset result", result, 32'h0);
      tick();
      reset = 1'b0;
      tick();

      run_op("sra 80000000>>4", 1'b1, 32'h80000000, 5'd4, 32'hF8000000);
      run_op("sll 1<<31", 1'b0, 32'h00000001, 5'd31, 32'h80000000);
      run_op("sra 7fffffff>>31", 1'b1, 32'h7FFFFFFF, 5'd31, 32'h00000000);
      run_op("sra ffffffff>>31", 1'b1, 32'hFFFFFFFF, 5'd31, 32'hFFFFFFFF);
      run_op("sll shamt0", 1'b0, 32'h12345678, 5'd0, 32'h12345678);
      run_op("sra shamt0", 1'b1, 32'h12345678, 5'd0, 32'h12345678);
      run_op("sra pos >>3", 1'b1, 32'h40000010, 5'd3, 32'h08000002);

      // Start pulsed mid-SHIFT must be ignored.
      op = 1'b0; operand = 32'h0000000F; shamt = 5'd8; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      op = 1'b1; operand = 32'hDEADBEEF; shamt = 5'd3; start = 1'b1;
      tick();
      start = 1'b0;
      nbusy = 3;
      while (busy && nbusy < 40) begin
         nbusy++;
         tick();
      end
      check("ignore busy cycles", nbusy, 8);
      check("ignore ready", ready, 1'b1);
      check("ignore result", result, 32'h00000F00);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("ignore idle hold", result, 32'h00000F00);
      end

      // Start held high: DONE -> IDLE, then the next IDLE edge accepts.
      op = 1'b0; operand = 32'h00000003; shamt = 5'd1; start = 1'b1;
      tick();
      check("held busy e0", busy, 1'b1);
      tick();
      check("held ready e1", ready, 1'b1);
      check("held result e1", result, 32'h00000006);
      operand = 32'h00000005;
      tick();
      check("held idle e2", {busy, ready}, 2'b00);
      tick();
      start = 1'b0;
      check("held reaccept e3", busy, 1'b1);
      tick();
      check("held result e4", result, 32'h0000000A);
      tick();

      // Reset at edge 3 of a 10-step operation.
      op = 1'b0; operand = 32'h00000001; shamt = 5'd10; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      @(posedge clock);
      reset = 1'b1;
      #1;
      check("abort busy", busy, 1'b0);
      check("abort ready", ready, 1'b0);
      check("abort result", result, 32'h0);
      tick();
      reset = 1'b0;
      nready = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (ready || busy) nready++;
      end
      check("abort no ready", nready, 0);
      check("abort result stays", result, 32'h0);
      run_op("post reset sll", 1'b0, 32'h00000001, 5'd1, 32'h00000002);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/shift_unit_seq.md
SHIFT_UNIT_SEQ -- requirements
Module: shift_unit_seq

Interface
Parameters: none; data width fixed at 32, shift amount fixed at 5 bits.
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clock and reset.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high; clears all state.
REQ-004 start  input  1  request; sampled on a rising edge.
REQ-005 op  input  1  0 = logical left shift (SLL), 1 = arithmetic right shift (SRA); sampled with start.
REQ-006 operand  input  32  value to shift; sampled with start.
REQ-007 shamt  input  5  shift amount 0..31; sampled with start.
REQ-008 busy  output  1  high while shifting (state SHIFT).
REQ-009 ready  output  1  one-cycle pulse; result valid and complete.
REQ-010 result  output  32  shifted value.

Function
REQ-011 The block SHALL be a multicycle shifter that applies one 1-bit shift per clock.
REQ-012 States SHALL be IDLE, SHIFT and DONE, with IDLE entered on reset.
REQ-013 IDLE with start=1 at a rising edge: the block SHALL capture operand into the working register and op into an op register, and load the counter with shamt.
REQ-014 In the same IDLE transition, the next state SHALL be DONE if shamt=0 and SHIFT otherwise.
REQ-015 IDLE with start=0: the block SHALL stay in IDLE and hold result unchanged.
REQ-016 SHIFT, at each rising edge, SLL: the working register SHALL become {w[30:0],1'b0}.
REQ-017 SHIFT, at each rising edge, SRA: the working register SHALL become {w[31],w[31:1]}, replicating the sign bit.
REQ-018 SHIFT, at each rising edge, the counter SHALL decrement by 1.
REQ-019 The block SHALL go SHIFT->DONE on the edge where the counter is 1, and that edge SHALL perform the final shift.
REQ-020 DONE SHALL last exactly one cycle with ready=1, then go to IDLE unconditionally.
REQ-021 Latency: counting the accepting edge as edge 0, ready SHALL be high during the cycle after edge max(shamt,0); shamt=0 gives ready after edge 0, and shamt=n gives ready after edge n.
REQ-022 result SHALL equal the working register and SHALL be final in DONE.
REQ-023 result SHALL hold its value through IDLE until the next accepted start.
REQ-024 busy SHALL be 1 only in SHIFT, and ready SHALL be 1 only in DONE; the two SHALL never be high together.
REQ-025 start in SHIFT or DONE SHALL be ignored with no capture and no queuing; the requester re-asserts start in IDLE.
REQ-026 operand, shamt and op changing after capture SHALL have no effect on the operation in flight.
REQ-027 SLL SHALL discard bits shifted out of bit 31, and SRA SHALL discard bits shifted out of bit 0.
REQ-028 No overflow or carry indication SHALL be produced.
REQ-029 The counter SHALL be 5 bits, SHALL never underflow, and SHALL NOT be decremented outside SHIFT.
REQ-030 With start held high continuously, the block SHALL accept a new request on the first IDLE edge following DONE.

Reset
REQ-031 reset=1 SHALL force, immediately and without waiting for clock, state=IDLE, busy=0, ready=0, result=32'h0, counter=0, and the op register cleared.
REQ-032 Reset asserted mid-SHIFT SHALL abort the operation, with no ready pulse afterward and no partial result retained.
REQ-033 After reset deasserts, the first rising edge with start=1 SHALL be accepted.

Verification
REQ-034 SRA, operand=32'h80000000, shamt=4, start for one cycle -> busy high for 4 cycles, then ready for 1 cycle with result=32'hF8000000.
REQ-035 SLL, operand=32'h00000001, shamt=31 -> ready after edge 31 with result=32'h80000000; busy high for 31 cycles.
REQ-036 SRA, operand=32'h7FFFFFFF, shamt=31 -> result=32'h00000000; SRA, operand=32'hFFFFFFFF, shamt=31 -> result=32'hFFFFFFFF.
REQ-037 shamt=0, operand=32'h12345678, either op -> busy never high, ready in the cycle after edge 0, result=32'h12345678.
REQ-038 SLL, operand=32'h0000000F, shamt=8; start pulsed again mid-SHIFT with operand=32'hDEADBEEF -> ignored; result=32'h00000F00; result held through the subsequent IDLE cycles.
REQ-039 Reset asserted at edge 3 of a shamt=10 operation -> busy, ready and result go to 0 asynchronously; no ready pulse afterward; a fresh SLL of 32'h1 by 1 then gives result=32'h00000002.
